// File: rtl/odelay_load_sequencer_pkg.sv
// Shared PHY definitions for the output-delay load sequencer: FSM encoding,
// delay-field widths and the fine-step saturation helper.
package odelay_load_sequencer_pkg;

  localparam int unsigned COARSE_W = 5;
  localparam int unsigned FINE_W   = 3;
  localparam logic [FINE_W-1:0] FINE_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SET    = 2'd2,
    ST_SETTLE = 2'd3
  } seq_state_e;

  function automatic logic fine_over(input logic [COARSE_W+FINE_W-1:0] d);
    return d[FINE_W-1:0] > FINE_MAX;
  endfunction

  // Clamp the fine step to FINE_MAX, leaving the coarse tap untouched.
  function automatic logic [COARSE_W+FINE_W-1:0] sat_delay(input logic [COARSE_W+FINE_W-1:0] d);
    logic [COARSE_W-1:0] coarse;
    coarse = d[COARSE_W+FINE_W-1:FINE_W];
    return fine_over(d) ? {coarse, FINE_MAX} : d;
  endfunction

endpackage

// File: rtl/odelay_shadow_regs.sv
// Per-lane shadow delay registers with dirty bits, a single write port and a
// scan read port that clears the scanned lane's dirty bit.
module odelay_shadow_regs
  import odelay_load_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LANES  = 10,
  parameter int unsigned LANE_BITS  = 4,
  parameter logic [7:0]  DELAY_INIT = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [LANE_BITS-1:0] wr_lane,
  input  logic [7:0]           wr_data,
  input  logic [LANE_BITS-1:0] rd_lane,
  input  logic                 clr_en,
  output logic [7:0]           rd_data,
  output logic                 rd_dirty
);

  logic [7:0]           shadow_q [NUM_LANES];
  logic [7:0]           shadow_d [NUM_LANES];
  logic [NUM_LANES-1:0] dirty_q;
  logic [NUM_LANES-1:0] dirty_d;

  always_comb begin
    shadow_d = shadow_q;
    dirty_d  = dirty_q;
    rd_data  = DELAY_INIT;
    rd_dirty = 1'b0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (wr_en && (wr_lane == LANE_BITS'(i))) begin
        shadow_d[i] = wr_data;
        dirty_d[i]  = 1'b1;
      end
      // A scan clear beats a same-edge write: the read port forwards that write.
      if (clr_en && (rd_lane == LANE_BITS'(i))) begin
        dirty_d[i] = 1'b0;
      end
      if (rd_lane == LANE_BITS'(i)) begin
        rd_data  = shadow_q[i];
        rd_dirty = dirty_q[i];
      end
    end
    if (wr_en && (wr_lane == rd_lane)) begin
      rd_data  = wr_data;
      rd_dirty = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        shadow_q[i] <= DELAY_INIT;
      end
      dirty_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      dirty_q  <= dirty_d;
    end
  end

endmodule

// File: rtl/odelay_load_sequencer.sv
// Sequences shadowed per-lane delay updates onto a shared delay bus: per-lane
// load strobes for changed lanes, then one broadcast set, then a settle window.
module odelay_load_sequencer
  import odelay_load_sequencer_pkg::*;
#(
  parameter int unsigned NUM_LANES     = 10,
  parameter int unsigned LANE_BITS     = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  DELAY_INIT    = 8'h00
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [LANE_BITS-1:0] wr_lane,
  input  logic [7:0]           wr_delay,
  input  logic                 apply,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic                 err_clr,
  output logic [7:0]           dly_data,
  output logic [NUM_LANES-1:0] dly_ld,
  output logic                 dly_set
);

  localparam logic [LANE_BITS-1:0] LAST_LANE   = LANE_BITS'(NUM_LANES - 1);
  localparam logic [7:0]           LAST_SETTLE = 8'(SETTLE_CYCLES - 1);

  seq_state_e           state_q, state_d;
  logic [LANE_BITS-1:0] k_q, k_d;
  logic [7:0]           settle_q, settle_d;
  logic                 pend_q, pend_d;
  logic                 ready_q, ready_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;
  logic                 dly_set_q, dly_set_d;
  logic [7:0]           dly_data_q, dly_data_d;
  logic [NUM_LANES-1:0] dly_ld_q, dly_ld_d;

  logic                 wr_fire, lane_ok, sh_wr_en, clr_en, go;
  logic [7:0]           sh_wr_data, rd_data;
  logic                 rd_dirty;

  odelay_shadow_regs #(
    .NUM_LANES (NUM_LANES),
    .LANE_BITS (LANE_BITS),
    .DELAY_INIT(DELAY_INIT)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (sh_wr_en),
    .wr_lane (wr_lane),
    .wr_data (sh_wr_data),
    .rd_lane (k_d),
    .clr_en  (clr_en),
    .rd_data (rd_data),
    .rd_dirty(rd_dirty)
  );

  always_comb begin
    wr_fire    = wr_valid && ready_q;
    lane_ok    = 32'(wr_lane) < NUM_LANES;
    sh_wr_en   = wr_fire && lane_ok;
    sh_wr_data = sat_delay(wr_delay);
    err_d      = (err_q && !err_clr) || (wr_fire && (!lane_ok || fine_over(wr_delay)));

    state_d    = state_q;
    k_d        = k_q;
    settle_d   = settle_q;
    pend_d     = pend_q || (apply && (state_q != ST_IDLE));
    go         = apply || pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d = ST_LOAD;
          k_d     = '0;
          pend_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (k_q == LAST_LANE) begin
          state_d = ST_SET;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_SET: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == LAST_SETTLE) begin
          // A merged pending apply restarts straight from the done cycle.
          if (go) begin
            state_d = ST_LOAD;
            k_d     = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          settle_d = settle_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    clr_en     = 1'b0;
    dly_ld_d   = '0;
    dly_data_d = dly_data_q;
    if (state_d == ST_LOAD) begin
      clr_en     = 1'b1;
      dly_data_d = rd_data;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        dly_ld_d[i] = rd_dirty && (k_d == LANE_BITS'(i));
      end
    end
    dly_set_d = (state_d == ST_SET);
    done_d    = (state_d == ST_SETTLE) && (settle_d == LAST_SETTLE);
    ready_d   = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      settle_q   <= '0;
      pend_q     <= 1'b0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      dly_set_q  <= 1'b0;
      dly_data_q <= DELAY_INIT;
      dly_ld_q   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      settle_q   <= settle_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      done_q     <= done_d;
      dly_set_q  <= dly_set_d;
      dly_data_q <= dly_data_d;
      dly_ld_q   <= dly_ld_d;
    end
  end

  assign wr_ready = ready_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign err      = err_q;
  assign dly_data = dly_data_q;
  assign dly_ld   = dly_ld_q;
  assign dly_set  = dly_set_q;

endmodule

// File: doc/odelay_load_sequencer.md
Name: odelay_load_sequencer

Overview:
Sequences delay updates for a group of fine-pipelined output-delay lanes that share one 8-bit delay bus. Software or a training FSM writes per-lane 8-bit delays into shadow registers. On an apply request, the block pulses the per-lane load strobes for changed lanes, then issues one broadcast set, so all lanes switch delay on the same clock edge. It sits between the memory-PHY control registers and the array of delay wrappers.

Parameters:
- NUM_LANES, 10, number of delay lanes driven.
- LANE_BITS, 4, width of the lane index; must satisfy 2**LANE_BITS >= NUM_LANES.
- SETTLE_CYCLES, 4, idle cycles after set before done (range 1..255).
- DELAY_INIT, 8'h00, shadow reset value; must match the lanes' reset delay.

Ports:
- clk  in  1  single clock, shared with the delay lanes.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  shadow-write request.
- wr_ready  out  1  shadow write accepted this cycle when wr_valid && wr_ready.
- wr_lane  in  LANE_BITS  target lane index.
- wr_delay  in  8  [7:3] coarse tap, [2:0] fine step.
- apply  in  1  single-cycle request to apply pending shadows.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at the end of a sequence.
- err  out  1  sticky error flag.
- err_clr  in  1  clears err.
- dly_data  out  8  shared delay bus to all lanes.
- dly_ld  out  NUM_LANES  per-lane load-pipe strobe.
- dly_set  out  1  broadcast set to all lanes.

Behaviour:
Reset (async, rst=1):
- FSM goes to IDLE.
- All shadows are set to DELAY_INIT.
- Dirty bits and apply_pending are cleared.
- Outputs: busy=0, done=0, err=0, dly_ld=0, dly_set=0, dly_data=DELAY_INIT, wr_ready=0 while rst=1, 1 on the first cycle after release.

Shadow writes:
- wr_ready=1 only in IDLE.
- On an accepted write: shadow[wr_lane] <= wr_delay and dirty[wr_lane] <= 1.
- Fine field > 4: stored as 4 (coarse field unchanged) and err is set.
- wr_lane >= NUM_LANES: write is consumed but discarded, and err is set.
- Rewriting a dirty lane overwrites the shadow; the lane stays dirty.

Apply:
- apply in IDLE starts the sequence on the next cycle.
- apply while busy sets apply_pending. The pending apply starts a new sequence on the cycle after done; further applies while pending are merged into it.
- Same-cycle wr + apply in IDLE: the write is committed first and is included in this sequence.

FSM: IDLE -> LOAD -> SET -> SETTLE -> IDLE.
- LOAD: lasts exactly NUM_LANES cycles with lane counter k = 0..NUM_LANES-1.
  - dly_data = shadow[k] on every cycle.
  - dly_ld[k] = dirty[k]; all other bits are 0.
  - dirty[k] is cleared as it is scanned.
- SET: one cycle with dly_set=1 and dly_ld=0.
- SETTLE: lasts SETTLE_CYCLES cycles. done=1 on the last SETTLE cycle, then the FSM returns to IDLE.

Latency and timing:
- busy=1 from the cycle after apply through the done cycle, inclusive.
- Total busy duration is NUM_LANES+1+SETTLE_CYCLES cycles.
- An apply with no dirty lanes still runs the full sequence (harmless re-set) and gives identical timing.

dly_data:
- Outside LOAD, it holds its last value.
- dly_ld and dly_set are registered outputs and never overlap.

err:
- Sticky until err_clr or rst.
- If err_clr and a new error occur in the same cycle, err=1 (set wins).

Reset mid-sequence:
- The sequence is aborted and no done is issued.
- Shadows revert to DELAY_INIT, consistent with the lanes' own reset.

Decomposition:
- Shared PHY package holds:
  - FSM state encoding (IDLE, LOAD, SET, SETTLE);
  - fine-step limit constant FINE_MAX=3'd4;
  - delay-field widths (COARSE_W=5, FINE_W=3).
- One sub-module, odelay_shadow_regs: NUM_LANES x 8 shadow array with dirty bits, write port, read mux on lane index, and clear-on-scan.
- The FSM, counter and error logic stay in the top module.

Test Plan:
1. Reset release -> dly_data=8'h00, dly_ld=0, dly_set=0, wr_ready=1 next cycle. Then apply with no writes -> dly_ld never asserted; dly_set at cycle 11; done at cycle 15 (NUM_LANES=10, SETTLE_CYCLES=4).
2. Write lane 3 = 8'h2C, lane 7 = 8'h11, then apply -> dly_ld[3]=1 with dly_data=8'h2C on LOAD cycle 3; dly_ld[7]=1 with dly_data=8'h11 on LOAD cycle 7; one dly_set pulse; no other strobes.
3. Write lane 2 = 8'h0F (fine=7) -> shadow stores 8'h0C and err=1. Write lane 12 -> discarded and err=1. err_clr -> err=0.
4. Apply asserted during LOAD, then again during SETTLE -> exactly one follow-on sequence starts the cycle after done; busy drops only after the second done.
5. Same-cycle wr (lane 0 = 8'h40) and apply in IDLE -> lane 0 is loaded in the same sequence (dly_ld[0]=1 on LOAD cycle 0 with dly_data=8'h40).
6. Assert rst during LOAD at k=5 -> dly_ld=0 immediately, no dly_set, no done. Then apply after reset -> no lanes loaded (dirty cleared).
